irq_pend_ctrl: RTL and testbench

Upstream front-end of the interrupt controller. It synchronizes the external interrupt lines, applies per-vector edge/level triggering, and holds the pending state. It presents a registered pended vector that the controller ORs into its entry pended bits. The controller acknowledges a taken interrupt back to this block, which clears the edge pend. This block owns two CSRs, mode and pend, on the shared CSR bus.

---
 rtl/irq_pend_ctrl_pkg.sv | 37 +++
 rtl/irq_pend_ctrl_sync_ff.sv | 35 +++
 rtl/irq_pend_ctrl.sv | 111 +++++++++++
 tb/tb_irq_pend_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pend_ctrl_pkg.sv
// Shared types and CSR map for the interrupt front-end.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: csr_addr_t, word, r, csr_op_t, the mode/pend CSR addresses, and
// helpers that pick the CSR source operand and decide whether an op writes.
package irq_pend_ctrl_pkg;

  typedef logic [11:0] csr_addr_t;
  typedef logic [31:0] word;
  typedef logic [4:0]  r;

  // funct3-style encoding; bit 2 distinguishes the immediate variants.
  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_t;

  localparam csr_addr_t IRQ_MODE_ADDR = 12'hb40;
  localparam csr_addr_t IRQ_PEND_ADDR = 12'hb41;

  function automatic word csr_src(input csr_op_t op, input word rs1, input r zimm);
    if (op == CSRRWI || op == CSRRSI || op == CSRRCI) begin
      return {27'b0, zimm};
    end
    return rs1;
  endfunction

  // Set/clear with a zero operand is a pure read and must not disturb state.
  function automatic logic csr_writes(input csr_op_t op, input word src);
    return (op == CSRRW) || (op == CSRRWI) || (src != '0);
  endfunction

endpackage

// File: rtl/irq_pend_ctrl_sync_ff.sv
// Multi-stage, multi-bit synchronizer for asynchronous inputs.
// Latency: Stages clock cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk, rst_n (async active-low), d (raw async input), q (synchronized).
module irq_pend_ctrl_sync_ff #(
  parameter int unsigned Stages = 2,
  parameter int unsigned Width  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Stages-1:0][Width-1:0] chain_q;
  logic [Stages-1:0][Width-1:0] chain_d;

  always_comb begin
    chain_d[0] = d;
    for (int unsigned i = 1; i < Stages; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[Stages-1];

endmodule

// File: rtl/irq_pend_ctrl.sv
// Interrupt front-end: synchronizes irq lines, applies edge/level trigger, holds pend state.
// Latency: level vectors pend SyncStages cycles after irq_in rises, edge vectors SyncStages+1.
// Backpressure: none; ack and CSR accesses are accepted every cycle.
// Ports: clk, reset (async active-low), irq_in (raw lines), CSR bus (csr_enable, csr_addr,
// csr_op, rs1_data, rs1_zimm, out read data), ack_valid/ack_vec (taken interrupt), pended.
module irq_pend_ctrl
  import irq_pend_ctrl_pkg::*;
#(
  parameter int unsigned VecSize     = 8,
  parameter int unsigned SyncStages  = 2,
  parameter csr_addr_t   IrqModeAddr = IRQ_MODE_ADDR,
  parameter csr_addr_t   IrqPendAddr = IRQ_PEND_ADDR,
  localparam int unsigned AckW       = (VecSize > 1) ? $clog2(VecSize) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VecSize-1:0] irq_in,
  input  logic               csr_enable,
  input  csr_addr_t          csr_addr,
  input  r                   rs1_zimm,
  input  word                rs1_data,
  input  csr_op_t            csr_op,
  input  logic               ack_valid,
  input  logic [AckW-1:0]    ack_vec,
  output logic [31:0]        out,
  output logic [VecSize-1:0] pended
);

  logic [VecSize-1:0] sync_s;
  logic [VecSize-1:0] prev_q, prev_d;
  logic [VecSize-1:0] mode_q, mode_d;
  logic [VecSize-1:0] edge_q, edge_d;
  logic [VecSize-1:0] rise;
  logic [VecSize-1:0] ack_mask;
  logic [VecSize-1:0] pended_int;
  logic [VecSize-1:0] old_sel;
  logic [VecSize-1:0] wval;
  logic [VecSize-1:0] src_v;
  logic [VecSize-1:0] base;
  word                src;
  logic               wr_en;
  logic               mode_hit;
  logic               pend_hit;

  irq_pend_ctrl_sync_ff #(
    .Stages (SyncStages),
    .Width  (VecSize)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (irq_in),
    .q     (sync_s)
  );

  assign rise       = sync_s & ~prev_q;
  // Level vectors bypass the pend register and follow the synchronized line.
  assign pended_int = (mode_q & edge_q) | (~mode_q & sync_s);
  assign pended     = pended_int;

  assign mode_hit = (csr_addr == IrqModeAddr);
  assign pend_hit = (csr_addr == IrqPendAddr);

  // Read returns the pre-write value; the bus is released on any other address.
  assign out = mode_hit ? word'(mode_q) :
               pend_hit ? word'(pended_int) : 'z;

  always_comb begin
    ack_mask = '0;
    for (int unsigned k = 0; k < VecSize; k++) begin
      ack_mask[k] = ack_valid && (ack_vec == AckW'(k));
    end
  end

  always_comb begin
    prev_d = sync_s;
    src    = csr_src(csr_op, rs1_data, rs1_zimm);
    src_v  = src[VecSize-1:0];
    wr_en  = csr_enable && csr_writes(csr_op, src);

    // Both CSRs share one read-modify-write path; only one address can hit.
    old_sel = mode_hit ? mode_q : pended_int;
    case (csr_op)
      CSRRW, CSRRWI: wval = src_v;
      CSRRS, CSRRSI: wval = old_sel | src_v;
      default:       wval = old_sel & ~src_v;
    endcase

    mode_d = (wr_en && mode_hit) ? wval : mode_q;

    // Write, then ack-clear, then set from a new rise: a rise in the same
    // cycle as a clear is never lost.
    base   = (wr_en && pend_hit) ? wval : edge_q;
    base   = base & ~ack_mask;
    // Masking with old and new mode keeps level bits at 0, clears a bit
    // leaving edge mode, and starts a bit entering edge mode from 0.
    edge_d = (base | rise) & mode_q & mode_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      mode_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= prev_d;
      mode_q <= mode_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Self-checking bench for irq_pend_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the pend rules.
module tb_irq_pend_ctrl;
  import irq_pend_ctrl_pkg::*;

  localparam int VS = 8;
  localparam int SS = 2;

  logic      clk = 1'b0;
  logic      reset;
  logic [7:0] irq_in;
  logic      csr_enable;
  csr_addr_t csr_addr;
  r          rs1_zimm;
  word       rs1_data;
  csr_op_t   csr_op;
  logic      ack_valid;
  logic [2:0] ack_vec;
  tri1 [31:0] out_w;
  logic [7:0] pended;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  irq_pend_ctrl #(
    .VecSize     (VS),
    .SyncStages  (SS),
    .IrqModeAddr (12'hb40),
    .IrqPendAddr (12'hb41)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .csr_enable (csr_enable),
    .csr_addr   (csr_addr),
    .rs1_zimm   (rs1_zimm),
    .rs1_data   (rs1_data),
    .csr_op     (csr_op),
    .ack_valid  (ack_valid),
    .ack_vec    (ack_vec),
    .out        (out_w),
    .pended     (pended)
  );

  // ---------------- behavioural model ----------------
  logic [7:0] m_mode;
  logic [7:0] m_pend;              // edge pend bits
  logic [7:0] m_hist [0:SS];       // m_hist[i] = irq_in as sampled i+1 edges ago

  function automatic logic [31:0] csr_result(input csr_op_t op, input logic [31:0] old,
                                             input logic [4:0] z, input logic [31:0] d,
                                             output logic wr);
    logic [31:0] s;
    s = (op == CSRRWI || op == CSRRSI || op == CSRRCI) ? {27'b0, z} : d;
    case (op)
      CSRRW, CSRRWI: begin wr = 1'b1;      return s;         end
      CSRRS, CSRRSI: begin wr = (s != 0);  return old | s;   end
      default:       begin wr = (s != 0);  return old & ~s;  end
    endcase
  endfunction

  function automatic logic [7:0] visible(input logic [7:0] mode, input logic [7:0] pend,
                                         input logic [7:0] line);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = mode[k] ? pend[k] : line[k];
    return v;
  endfunction

  function automatic logic [15:0] model_next(input logic [7:0] mode, input logic [7:0] pend,
                                             input logic [7:0] line, input logic [7:0] prev);
    logic [7:0]  new_mode, new_pend, wv, rise;
    logic [31:0] res;
    logic        wr, pend_w;
    rise     = line & ~prev;
    new_mode = mode;
    pend_w   = 1'b0;
    wv       = 8'h00;
    if (csr_enable && csr_addr == 12'hb40) begin
      res = csr_result(csr_op, {24'b0, mode}, rs1_zimm, rs1_data, wr);
      if (wr) new_mode = res[7:0];
    end
    if (csr_enable && csr_addr == 12'hb41) begin
      res = csr_result(csr_op, {24'b0, visible(mode, pend, line)}, rs1_zimm, rs1_data, wr);
      pend_w = wr;
      wv     = res[7:0];
    end
    for (int k = 0; k < 8; k++) begin
      if (mode[k] && new_mode[k]) begin
        new_pend[k] = pend[k];
        if (pend_w) new_pend[k] = wv[k];
        if (ack_valid && int'(ack_vec) == k) new_pend[k] = 1'b0;
        if (rise[k]) new_pend[k] = 1'b1;
      end else begin
        new_pend[k] = 1'b0;
      end
    end
    return {new_mode, new_pend};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 8'h00;
      m_pend <= 8'h00;
      for (int i = 0; i <= SS; i++) m_hist[i] <= 8'h00;
    end else begin
      {m_mode, m_pend} <= model_next(m_mode, m_pend, m_hist[SS-1], m_hist[SS]);
      m_hist[0] <= irq_in;
      for (int i = 1; i <= SS; i++) m_hist[i] <= m_hist[i-1];
    end
  end

  function automatic logic [31:0] exp_out(input csr_addr_t a, input logic [7:0] vis);
    if (a == 12'hb40) return {24'b0, m_mode};
    if (a == 12'hb41) return {24'b0, vis};
    return 32'hFFFF_FFFF;   // released bus reads as pulled-up
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pended", {24'b0, pended},
            {24'b0, visible(m_mode, m_pend, m_hist[SS-1])});
      check("model_out", out_w, exp_out(csr_addr, visible(m_mode, m_pend, m_hist[SS-1])));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic csr_wr(input csr_addr_t a, input csr_op_t op, input word d, input r z);
    csr_enable = 1'b1;
    csr_addr   = a;
    csr_op     = op;
    rs1_data   = d;
    rs1_zimm   = z;
    step();
    csr_enable = 1'b0;
  endtask

  task automatic ack(input logic [2:0] v);
    ack_valid = 1'b1;
    ack_vec   = v;
    step();
    ack_valid = 1'b0;
  endtask

  csr_op_t ops [6] = '{CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};

  initial begin
    reset      = 1'b0;
    irq_in     = 8'h00;
    csr_enable = 1'b0;
    csr_addr   = 12'hb40;
    rs1_zimm   = 5'h00;
    rs1_data   = 32'h0;
    csr_op     = CSRRW;
    ack_valid  = 1'b0;
    ack_vec    = 3'd0;
    steps(2);
    chk_en = 1'b1;

    // Reset state
    at_neg();
    check("rst_pended", {24'b0, pended}, 32'h0);
    check("rst_mode_rd", out_w, 32'h0);

    // Level latency
    step();
    reset  = 1'b1;
    irq_in = 8'h04;
    step();
    at_neg();
    check("lvl_lat1", {24'b0, pended}, 32'h00);
    step();
    at_neg();
    check("lvl_lat2", {24'b0, pended}, 32'h04);
    step();
    irq_in = 8'h00;
    steps(2);
    at_neg();
    check("lvl_drop", {24'b0, pended}, 32'h00);

    // Edge mode on vector 0
    step();
    csr_wr(12'hb40, CSRRWI, 32'h0, 5'h01);
    at_neg();
    check("mode_rd", out_w, 32'h1);
    step();
    irq_in = 8'h01;
    step();
    irq_in = 8'h00;
    step();
    at_neg();
    check("edge_lat2", {24'b0, pended}, 32'h00);
    step();
    at_neg();
    check("edge_lat3", {24'b0, pended}, 32'h01);
    steps(3);
    at_neg();
    check("edge_hold", {24'b0, pended}, 32'h01);
    step();
    ack(3'd0);
    at_neg();
    check("ack_clr", {24'b0, pended}, 32'h00);

    // Rise in the same cycle as ack: set wins (from clear, then from pended)
    for (int it = 0; it < 2; it++) begin
      step();
      irq_in = 8'h01;
      step();
      irq_in = 8'h00;
      step();
      ack(3'd0);
      at_neg();
      check("set_wins", {24'b0, pended}, 32'h01);
    end

    // Pend CSR set/clear in all-edge mode
    step();
    csr_wr(12'hb40, CSRRW, 32'hFF, 5'h0);
    ack(3'd0);
    csr_wr(12'hb41, CSRRS, 32'h30, 5'h0);
    at_neg();
    check("pend_rs", {24'b0, pended}, 32'h30);
    check("pend_rd", out_w, 32'h30);
    step();
    csr_wr(12'hb41, CSRRC, 32'h10, 5'h0);
    at_neg();
    check("pend_rc", {24'b0, pended}, 32'h20);

    // Mode leaving edge clears the pend
    step();
    csr_wr(12'hb41, CSRRSI, 32'h0, 5'h01);
    at_neg();
    check("pend_rsi", {24'b0, pended}, 32'h21);
    step();
    csr_wr(12'hb40, CSRRW, 32'h01, 5'h0);
    at_neg();
    check("mode_to_01", {24'b0, pended}, 32'h01);
    step();
    csr_wr(12'hb40, CSRRC, 32'h01, 5'h0);
    at_neg();
    check("mode_clr", {24'b0, pended}, 32'h00);
    step();
    csr_addr = 12'hb42;
    at_neg();
    check("miss_z", out_w, 32'hFFFF_FFFF);

    // Async reset mid-stream with lines held high
    step();
    irq_in = 8'hFF;
    csr_wr(12'hb40, CSRRW, 32'h0F, 5'h0);
    steps(4);
    at_neg();
    check("all_pend", {24'b0, pended}, 32'hFF);
    step();
    #2 reset = 1'b0;
    at_neg();
    check("rst_async", {24'b0, pended}, 32'h00);
    step();
    reset = 1'b1;
    steps(2);
    at_neg();
    check("lvl_repend", {24'b0, pended}, 32'hFF);
    step();
    csr_wr(12'hb40, CSRRW, 32'h0F, 5'h0);
    at_neg();
    check("edge_norise", {24'b0, pended}, 32'hF0);
    steps(3);
    at_neg();
    check("edge_norise2", {24'b0, pended}, 32'hF0);

    // Randomized traffic, model-checked every cycle
    step();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 8'($urandom);
      csr_enable = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: csr_addr = 12'hb40;
        1: csr_addr = 12'hb41;
        2: csr_addr = 12'hb42;
        default: csr_addr = 12'($urandom);
      endcase
      csr_op    = ops[$urandom_range(0, 5)];
      rs1_data  = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'h0000_01FF);
      rs1_zimm  = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom);
      ack_valid = ($urandom_range(0, 3) == 0);
      ack_vec   = 3'($urandom);
      if (c % 700 == 350) begin
        reset = 1'b0;
        steps(2);
        reset = 1'b1;
      end
      step();
    end
    csr_enable = 1'b0;
    ack_valid  = 1'b0;
    steps(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
